// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready flow control, stall, flush and optional skid entry.
// Optional PIPE_STAGE_PERF_EN adds saturating stall/bubble counters on stall_cnt_o/bubble_cnt_o.
module pipe_stage_reg #(
  parameter int unsigned DATA_W             = 32,
  parameter int unsigned CTRL_W             = 3,
  parameter int unsigned SKID               = 1,
  parameter int unsigned CLR_CTRL_ON_BUBBLE = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  input  logic              ready_i,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  input  logic              flush_i
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       bubble_cnt_o
`endif
);

  logic              mValidQ, mValidD;
  logic [CTRL_W-1:0] mCtrlQ, mCtrlD;
  logic [DATA_W-1:0] mDataQ, mDataD;
  logic              sValidQ, sValidD;
  logic [CTRL_W-1:0] sCtrlQ, sCtrlD;
  logic [DATA_W-1:0] sDataQ, sDataD;
  logic              accept;
  logic              mFree;

  // With SKID the ready path depends only on state, so no ready_i -> ready_o combinational path.
  always_comb begin
    if (reset) begin
      ready_o = 1'b0;
    end else if (SKID != 0) begin
      ready_o = !sValidQ;
    end else begin
      ready_o = ready_i || !mValidQ;
    end
  end

  assign accept = valid_i && ready_o;
  assign mFree  = ready_i || !mValidQ;

  always_comb begin
    mValidD = mValidQ;
    mCtrlD  = mCtrlQ;
    mDataD  = mDataQ;
    sValidD = sValidQ;
    sCtrlD  = sCtrlQ;
    sDataD  = sDataQ;
    if (flush_i) begin
      mValidD = 1'b0;
      sValidD = 1'b0;
    end else if (SKID != 0) begin
      if (mFree) begin
        if (sValidQ) begin
          mValidD = 1'b1;
          mCtrlD  = sCtrlQ;
          mDataD  = sDataQ;
          sValidD = 1'b0;
        end else if (accept) begin
          mValidD = 1'b1;
          mCtrlD  = ctrl_i;
          mDataD  = data_i;
        end else begin
          mValidD = 1'b0;
        end
      end else if (accept) begin
        // Downstream stalled while M is full: park the incoming bundle in S.
        sValidD = 1'b1;
        sCtrlD  = ctrl_i;
        sDataD  = data_i;
      end
    end else begin
      if (accept) begin
        mValidD = 1'b1;
        mCtrlD  = ctrl_i;
        mDataD  = data_i;
      end else if (ready_i && mValidQ) begin
        mValidD = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mValidQ <= 1'b0;
      mCtrlQ  <= '0;
      mDataQ  <= '0;
      sValidQ <= 1'b0;
      sCtrlQ  <= '0;
      sDataQ  <= '0;
    end else begin
      mValidQ <= mValidD;
      mCtrlQ  <= mCtrlD;
      mDataQ  <= mDataD;
      sValidQ <= sValidD;
      sCtrlQ  <= sCtrlD;
      sDataQ  <= sDataD;
    end
  end

  assign valid_o = mValidQ;
  assign data_o  = mDataQ;

  // Killed or empty slots must not leak RegWrite/PCSrc downstream.
  always_comb begin
    if (CLR_CTRL_ON_BUBBLE != 0 && !mValidQ) begin
      ctrl_o = '0;
    end else begin
      ctrl_o = mCtrlQ;
    end
  end

`ifdef PIPE_STAGE_PERF_EN
  logic [31:0] stallCntQ, bubbleCntQ;

  always_ff @(posedge clk) begin
    if (reset) begin
      stallCntQ  <= '0;
      bubbleCntQ <= '0;
    end else begin
      if (mValidQ && !ready_i && stallCntQ != '1) begin
        stallCntQ <= stallCntQ + 32'd1;
      end
      if (!mValidQ && ready_i && bubbleCntQ != '1) begin
        bubbleCntQ <= bubbleCntQ + 32'd1;
      end
    end
  end

  assign stall_cnt_o  = stallCntQ;
  assign bubble_cnt_o = bubbleCntQ;
`else
  // Counters not built; datapath is unchanged.
`endif

  // S only ever holds the younger of two bundles.
  skidImpliesMain: assert property (@(posedge clk) disable iff (reset) sValidQ |-> mValidQ);

  heldStable: assert property (@(posedge clk) disable iff (reset)
    (mValidQ && !ready_i && !flush_i) |=> (mValidQ && $stable(mDataQ) && $stable(mCtrlQ)));

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the pipelined ARM core. It generalises the fixed-field stage flops into one reusable block carrying a control bundle and a data bundle. It adds valid/ready flow control, stall, synchronous flush and an optional 2-entry skid buffer. It is instantiated between any two stages (D/E, E/M, M/W), so the hazard unit stalls or flushes a stage through ports rather than per-stage custom logic.

Parameters:
DATA_W, 32, width of data bundle (operands, ALU result, read data, Rd index packed by instantiator)
CTRL_W, 3, width of control bundle (e.g. {PCSrc, RegWrite, MemtoReg})
SKID, 1, 1 = 2-entry skid buffer with registered ready_o; 0 = single register with combinational ready_o
CLR_CTRL_ON_BUBBLE, 1, 1 = ctrl_o forced to 0 whenever valid_o=0

Ports:
clk  in  1  stage clock
reset  in  1  synchronous, active-high reset
valid_i  in  1  upstream stage holds a valid instruction
ready_o  out  1  this stage can accept this cycle
ctrl_i  in  CTRL_W  upstream control bundle
data_i  in  DATA_W  upstream data bundle
valid_o  out  1  downstream bundle valid
ready_i  in  1  downstream accepts (0 = stall from hazard unit)
ctrl_o  out  CTRL_W  registered control bundle
data_o  out  DATA_W  registered data bundle
flush_i  in  1  kill all held and incoming instructions

Behaviour:
- One clock; reset is synchronous and active-high. Ports are named clk and reset.
- Reset (sampled at posedge): valid_o=0, ctrl_o=0, data_o=0, skid entry empty.
- ready_o=0 in any cycle where reset=1; a handshake offered in that cycle is discarded.
- Accept = valid_i && ready_o. Emit = valid_o && ready_i.
- Latency: 1 cycle from accept to valid_o on an empty stage. Throughput: 1 per cycle while ready_i=1.
- Main register (M) drives outputs. Skid register (S) is present only when SKID=1.
- SKID=1:
  - ready_o = !S.valid (registered, no combinational path from ready_i).
  - If ready_i || !M.valid: M loads S if S.valid (S empties), else loads the input if Accept, else M.valid becomes 0.
  - If !(ready_i || !M.valid) and Accept: input is written into S.
  - S is never written while S.valid=1, because ready_o=0 in that state.
- SKID=0: ready_o = ready_i || !M.valid (combinational). M loads the input on Accept and clears valid on Emit without Accept.
- Held data: while valid_o=1 && ready_i=0, ctrl_o and data_o are stable. Ordering is strict FIFO, and no bundle is dropped or duplicated.
- Flush: flush_i=1 at posedge sets M.valid=0 and S.valid=0. Input offered that cycle is discarded. ready_o=1 the next cycle. Flush has priority over everything except reset.
- Bubble: when valid_o=0, ctrl_o=0 if CLR_CTRL_ON_BUBBLE=1, so RegWrite/PCSrc of a killed instruction never reach writeback. data_o holds its last value.
- Simultaneous Accept and Emit with M full and S empty: M is replaced with the input in the same edge, with no bubble.
- No arithmetic; widths pass through unchanged. DATA_W≥1 and CTRL_W≥1.

Optional Feature:
Macro PIPE_STAGE_PERF_EN.
- Defined: adds outputs stall_cnt_o[31:0] and bubble_cnt_o[31:0].
  - stall_cnt_o increments each cycle valid_o && !ready_i.
  - bubble_cnt_o increments each cycle !valid_o && ready_i.
  - Both counters saturate at 0xFFFFFFFF, clear on reset, and are unaffected by flush_i.
- Undefined: the ports and counters do not exist, and the datapath is identical.

Test Plan:
- Reset with valid_i=1, ctrl_i=3'b111, data_i=0xDEADBEEF held during reset -> valid_o=0, ctrl_o=0, data_o=0, ready_o=0; after deassert ready_o=1 and nothing from the reset cycle appears.
- Stream data 1..8, ready_i=1, SKID=1 -> valid_o from cycle 1, data_o=1..8 on consecutive cycles, no gaps.
- SKID=1: send A, B, C; drop ready_i low the cycle B is accepted -> data_o holds A, S captures B, ready_o=0, C waits. Raise ready_i -> A, B, C emitted in order, ready_o returns to 1.
- Full (M=A, S=B) with flush_i=1 and valid_i=1 (D) -> next cycle valid_o=0, ctrl_o=0, ready_o=1; D, A and B never emitted.
- SKID=0, M full, ready_i=1, valid_i=1 -> ready_o=1 combinationally and M replaced on the same edge; with ready_i=0 -> ready_o=0.
- PIPE_STAGE_PERF_EN: 5 stall cycles followed by 3 idle cycles with ready_i=1 -> stall_cnt_o=5, bubble_cnt_o=3; a flush leaves both counts unchanged.
